cs_stream_ctrl: RTL and testbench

//  Sequencer for the 9-tap CS datapath (core: 8-bit X in, 10-bit Y out, sliding window).
//  - Takes a valid/ready sample stream and drives the core's load/clear strobes.
//  - Suppresses outputs while the window is filling.
//  - Captures core results into a backpressured output port, splitting the stream into

---
 rtl/cs_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_cs_stream_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_stream_ctrl.sv
// rtl/cs_stream_ctrl.sv - sample/result sequencer for the 9-tap CS core; optional stats via CS_CTRL_STATS_EN
module cs_stream_ctrl #(
  parameter int WIN       = 9,
  parameter int FRAME_LEN = 64,
  parameter int CORE_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [7:0]  core_x,
  output logic        core_load,
  output logic        core_clr,
  input  logic [9:0]  core_y,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  m_data,
  output logic        m_last
`ifdef CS_CTRL_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_stall
`endif
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  // Countdown covers the core_load cycle plus CORE_LAT cycles of core latency.
  localparam logic [2:0] LAT_LOAD = 3'(CORE_LAT + 1);

  typedef enum logic [1:0] {ST_CLR, ST_FILL, ST_RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          busy;
  logic [2:0]    lat_cnt;
  logic          last_pend;
  logic          s_fire;
  logic          m_fire;

  assign cnt_inc = cnt + CW'(1);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  // Accept every cycle while filling; in RUN only with nothing in flight and nothing held,
  // so a result leaving the port blocks intake for that cycle.
  assign s_ready = (state == ST_FILL) || ((state == ST_RUN) && !busy && !m_valid);

  // Frame sequencer: clear the core, fill the window silently, then one result per sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLR;
      cnt       <= '0;
      busy      <= 1'b0;
      lat_cnt   <= '0;
      last_pend <= 1'b0;
      core_x    <= '0;
      core_load <= 1'b0;
      core_clr  <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      core_load <= 1'b0;
      core_clr  <= 1'b0;
      if (m_fire) begin
        m_valid <= 1'b0;
      end
      case (state)
        ST_CLR: begin
          core_clr <= 1'b1;
          cnt      <= '0;
          state    <= (WIN > 1) ? ST_FILL : ST_RUN;
        end
        ST_FILL: begin
          if (s_fire) begin
            core_load <= 1'b1;
            core_x    <= s_data;
            cnt       <= cnt_inc;
            if (cnt_inc == CW'(WIN - 1)) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (s_fire) begin
            core_load <= 1'b1;
            core_x    <= s_data;
            cnt       <= cnt_inc;
            busy      <= 1'b1;
            lat_cnt   <= LAT_LOAD;
            last_pend <= (cnt_inc == CW'(FRAME_LEN));
          end else if (busy) begin
            if (lat_cnt == 3'd0) begin
              m_data  <= core_y;
              m_last  <= last_pend;
              m_valid <= 1'b1;
              busy    <= 1'b0;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end
          if (m_fire && m_last) begin
            state <= ST_CLR;
          end
        end
        default: state <= ST_CLR;
      endcase
    end
  end

`ifdef CS_CTRL_STATS_EN
  // Completed-frame and output-stall counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_frames <= '0;
      stat_stall  <= '0;
    end else begin
      if (m_fire && m_last && (stat_frames != 16'hFFFF)) begin
        stat_frames <= stat_frames + 16'd1;
      end
      if (m_valid && !m_ready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// tb/tb_cs_stream_ctrl.sv - self-checking bench for cs_stream_ctrl with a behavioural CS core
module tb_cs_stream_ctrl;

  localparam int WIN       = 9;
  localparam int FRAME_LEN = 12;
  localparam int CORE_LAT  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [7:0] core_x;
  logic       core_load;
  logic       core_clr;
  logic [9:0] core_y;
  logic       m_valid;
  logic       m_ready;
  logic [9:0] m_data;
  logic       m_last;
`ifdef CS_CTRL_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_stall;
`endif

  cs_stream_ctrl #(.WIN(WIN), .FRAME_LEN(FRAME_LEN), .CORE_LAT(CORE_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .core_x    (core_x),
    .core_load (core_load),
    .core_clr  (core_clr),
    .core_y    (core_y),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef CS_CTRL_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural CS core: 9-sample sliding sum, one cycle from load to result.
  logic [7:0] cwin [WIN];
  always @(posedge clk) begin
    if (reset || core_clr) begin
      for (int i = 0; i < WIN; i++) cwin[i] <= '0;
      core_y <= '0;
    end else if (core_load) begin
      int acc;
      acc = int'(core_x);
      for (int i = 0; i < WIN - 1; i++) acc += int'(cwin[i]);
      cwin[0] <= core_x;
      for (int i = 1; i < WIN; i++) cwin[i] <= cwin[i-1];
      core_y <= 10'(acc);
    end
  end

  // Reference model: each accepted sample joins the frame; from the WIN-th sample on, the
  // expected result is the sum of the last WIN frame samples modulo 1024.
  logic [7:0]  frame_q [$];
  logic [10:0] exp_q [$];
  int load_cnt = 0, clr_cnt = 0, mval_cnt = 0, both_cnt = 0, hold_viol = 0;
  int tb_frames = 0, tb_stall = 0;
  logic       prev_hold = 1'b0;
  logic [9:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(posedge clk) begin
    if (core_load) load_cnt++;
    if (core_clr) clr_cnt++;
    if (core_load && core_clr) both_cnt++;
    if (m_valid) mval_cnt++;
    if (reset) begin
      frame_q.delete();
      exp_q.delete();
      tb_frames = 0;
      tb_stall  = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && !(m_valid && m_data == prev_data && m_last == prev_last)) hold_viol++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (m_valid && !m_ready) tb_stall++;
      if (s_valid && s_ready) begin
        frame_q.push_back(s_data);
        if (frame_q.size() >= WIN) begin
          int s;
          s = 0;
          for (int j = frame_q.size() - WIN; j < frame_q.size(); j++) s += int'(frame_q[j]);
          exp_q.push_back({frame_q.size() == FRAME_LEN, 10'(s % 1024)});
        end
        if (frame_q.size() == FRAME_LEN) frame_q.delete();
      end
      if (m_valid && m_ready) begin
        if (m_last) tb_frames++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'(m_data), 32'hFFFF);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("sb_data", 32'(m_data), 32'(e[9:0]));
          check("sb_last", 32'(m_last), 32'(e[10]));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("send_timeout", 32'(s_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int e);
    e = 0;
    while (!m_valid && e < 50) begin
      @(negedge clk);
      e++;
    end
    if (!m_valid) check("mvalid_timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         produce;
    logic [9:0] y;
    bit         last;
  } vec_t;

  vec_t tbl [FRAME_LEN];
  bit   rnd_done;

  initial begin
    int e;
    for (int i = 0; i < 8; i++) tbl[i] = '{8'(i + 1), 1'b0, 10'd0, 1'b0};
    tbl[8]  = '{8'd9,  1'b1, 10'd45, 1'b0};
    tbl[9]  = '{8'd10, 1'b1, 10'd54, 1'b0};
    tbl[10] = '{8'd11, 1'b1, 10'd63, 1'b0};
    tbl[11] = '{8'd12, 1'b1, 10'd72, 1'b1};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({s_ready, core_load, core_clr, core_x, m_valid, m_data, m_last}), 32'd0);
    reset = 1'b0; m_ready = 1'b1;
    load_cnt = 0; clr_cnt = 0; mval_cnt = 0;
    @(negedge clk);
    check("clr_after_reset", 32'(core_clr), 32'd1);

    // Frame 1: fill, first result latency, then the frame tail.
    for (int i = 0; i < FRAME_LEN; i++) begin
      send(tbl[i].d);
      if (i == 7) begin
        @(negedge clk);
        check("fill_loads", 32'(load_cnt), 32'd8);
        check("fill_no_mvalid", 32'(mval_cnt), 32'd0);
        check("fill_clr_once", 32'(clr_cnt), 32'd1);
      end
      if (tbl[i].produce) begin
        wait_mvalid(e);
        if (i == 8) check("first_latency", 32'(e), 32'd3);
        check($sformatf("tbl_data_%0d", i), 32'(m_data), 32'(tbl[i].y));
        check($sformatf("tbl_last_%0d", i), 32'(m_last), 32'(tbl[i].last));
      end
    end

    // Frame 2 fill: after the last result the core is cleared and 8 samples stay silent.
    for (int i = 1; i <= 8; i++) send(8'(100 + i));
    repeat (2) @(negedge clk);
    check("frame2_no_output", 32'(mval_cnt), 32'd4);
    check("frame2_clr_count", 32'(clr_cnt), 32'd2);

    // Backpressure: held result blocks intake; release lets the waiting sample in a cycle later.
    m_ready = 1'b0;
    send(8'd109);
    wait_mvalid(e);
    s_valid = 1'b1; s_data = 8'd110;
    for (int i = 0; i < 5; i++) begin
      check("hold_state", 32'({s_ready, m_valid, m_data}), 32'({1'b0, 1'b1, 10'd945}));
      @(negedge clk);
    end
    m_ready = 1'b1;
    check("release_cycle_sready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("after_release", 32'({s_ready, m_valid}), 32'({1'b1, 1'b0}));
    @(negedge clk);
    s_valid = 1'b0;
    check("next_sample_loaded", 32'({core_load, core_x}), 32'({1'b1, 8'd110}));
    send(8'd111);
    send(8'd112);
    drain();

    // Reset while a result is in flight.
    for (int i = 0; i < 9; i++) send(8'(50 + i));
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset", 32'({s_ready, core_load, core_clr, core_x, m_valid, m_data, m_last}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(200 + i));
    wait_mvalid(e);
    check("post_reset_sum_wrap", 32'({m_valid, m_data}), 32'({1'b1, 10'd812}));
    drain();

    // Randomised traffic with random backpressure across several frames.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(8'($urandom_range(0, 255)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
    join
    drain();

    check("load_clr_overlap", 32'(both_cnt), 32'd0);
    check("output_hold", 32'(hold_viol), 32'd0);
`ifdef CS_CTRL_STATS_EN
    check("stat_frames", 32'(stat_frames), 32'(tb_frames));
    check("stat_stall", 32'(stat_stall), 32'(tb_stall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
